// File: rtl/uart_frame_parser.sv
// Sync/length/payload/XOR-checksum frame parser behind a UART receiver.
// Optional inter-byte timeout enabled with `define UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [15:0] TIMEOUT_VAL = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       take,
  input  logic [7:0]                 din,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic [7:0]                 frame_len,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int unsigned AW        = $clog2(MAX_LEN);
  localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} state_t;

  state_t     state, state_nxt;
  logic       valid_nxt, err_nxt;
  logic [7:0] len_reg, csum, wr_ptr;
  logic [7:0] mem [MAX_LEN];
  logic       last_byte;

`ifdef UART_FRAME_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  assign tmo_hit = (state != IDLE) && !take && (tmo_cnt == '0);
`else
  logic tmo_hit;
  logic unused_timeout;
  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT_VAL;
`endif

  assign last_byte = (wr_ptr == (len_reg - 8'd1));

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != IDLE);
      frame_valid <= valid_nxt;
      frame_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: if (take && din == SYNC_BYTE) state_nxt = LEN;
      LEN: begin
        if (take) begin
          if ({1'b0, din} > MAX_LEN_W) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else if (din == 8'd0) begin
            state_nxt = CSUM;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: if (take && last_byte) state_nxt = CSUM;
      CSUM: begin
        if (take) begin
          if (din == csum) valid_nxt = 1'b1;
          else             err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // tmo_hit already excludes take, so a byte on the expiry cycle is processed
    if (tmo_hit) begin
      err_nxt   = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      len_reg   <= '0;
      csum      <= '0;
      wr_ptr    <= '0;
      frame_len <= '0;
    end else begin
      if (state == LEN && take) begin
        len_reg <= din;
        csum    <= din;
        wr_ptr  <= '0;
      end
      if (state == DATA && take) begin
        csum   <= csum ^ din;
        wr_ptr <= wr_ptr + 8'd1;
      end
      if (valid_nxt) frame_len <= len_reg;
    end
  end

  // Payload buffer: not reset; read port returns pre-write data on collision
  always_ff @(posedge clk) begin
    if (state == DATA && take) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (res) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

`ifdef UART_FRAME_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (res)                                    tmo_cnt <= '0;
    else if (take && state_nxt != IDLE)         tmo_cnt <= TIMEOUT_VAL;
    else if (state != IDLE && tmo_cnt != '0)    tmo_cnt <= tmo_cnt - 16'd1;
  end
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser (MAX_LEN=16, TIMEOUT_VAL=16).
module tb_uart_frame_parser;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       take = 1'b0;
  logic [7:0] din = '0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data, frame_len;
  logic       frame_valid, frame_err, busy;

  int checks = 0;
  int errors = 0;

  uart_frame_parser #(
    .SYNC_BYTE  (8'hA5),
    .MAX_LEN    (16),
    .TIMEOUT_VAL(16'h0010)
  ) dut (
    .clk        (clk),
    .res        (res),
    .take       (take),
    .din        (din),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_len  (frame_len),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte strobe held across edges so consecutive put() calls are back-to-back
  task automatic put(input logic [7:0] b);
    take = 1'b1;
    din  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    take = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    take    = 1'b0;
    rd_addr = a;
    @(posedge clk);
    #1;
    chk(tag, rd_data, exp);
  endtask

  initial begin
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", frame_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_rd", rd_data, 0);
    res = 1'b0;
    idle();

    // Noise outside a frame
    put(8'h00); put(8'hFF); idle();
    chk("noise_busy", busy, 0);
    chk("noise_err", frame_err, 0);

    // Good frame A5 03 11 22 33 03
    put(8'hA5);
    chk("good_busy_after_sync", busy, 1);
    put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h03);
    chk("good_valid", frame_valid, 1);
    chk("good_err", frame_err, 0);
    chk("good_len", frame_len, 3);
    chk("good_busy_done", busy, 0);
    idle();
    chk("good_valid_one_cycle", frame_valid, 0);
    rd(4'd0, 8'h11, "good_rd0");
    rd(4'd1, 8'h22, "good_rd1");
    rd(4'd2, 8'h33, "good_rd2");

    // Bad checksum A5 02 10 20 31 (expected 32)
    put(8'hA5); put(8'h02); put(8'h10); put(8'h20); put(8'h31);
    chk("badcs_err", frame_err, 1);
    chk("badcs_valid", frame_valid, 0);
    chk("badcs_len_kept", frame_len, 3);
    chk("badcs_busy", busy, 0);
    idle();
    chk("badcs_err_one_cycle", frame_err, 0);
    put(8'hA5); put(8'h01); put(8'h7E); put(8'h7F);
    chk("after_bad_valid", frame_valid, 1);
    chk("after_bad_len", frame_len, 1);
    rd(4'd0, 8'h7E, "after_bad_rd0");

    // Length over MAX_LEN
    put(8'hA5); put(8'h11);
    chk("len17_err", frame_err, 1);
    chk("len17_busy", busy, 0);
    idle();

    // Length exactly MAX_LEN: payload 00..0F, checksum 10
    put(8'hA5); put(8'h10);
    chk("len16_no_err", frame_err, 0);
    chk("len16_busy", busy, 1);
    for (int i = 0; i < 16; i++) put(8'(i));
    put(8'h10);
    chk("len16_valid", frame_valid, 1);
    chk("len16_len", frame_len, 16);
    rd(4'd15, 8'h0F, "len16_rd15");

    // Zero-length frame
    put(8'hA5); put(8'h00); put(8'h00);
    chk("len0_valid", frame_valid, 1);
    chk("len0_len", frame_len, 0);
    idle();

    // Write/read collision at address 0 returns the old byte (00)
    rd_addr = 4'd0;
    put(8'hA5); put(8'h01); put(8'hC3);
    chk("collide_old", rd_data, 8'h00);
    put(8'hC2);
    chk("collide_new", rd_data, 8'hC3);
    chk("collide_valid", frame_valid, 1);

    // Back-to-back frames, second carries a sync byte as payload
    put(8'hA5); put(8'h01); put(8'h55); put(8'h54);
    chk("b2b_first_valid", frame_valid, 1);
    put(8'hA5);
    chk("b2b_pulse_drop", frame_valid, 0);
    put(8'h02); put(8'hA5); put(8'h01); put(8'hA6);
    chk("b2b_second_valid", frame_valid, 1);
    chk("b2b_second_len", frame_len, 2);
    idle();
    rd(4'd0, 8'hA5, "b2b_rd0");

    // Stall mid-frame after A5 02 11
    put(8'hA5); put(8'h02); put(8'h11);
`ifdef UART_FRAME_TIMEOUT_EN
    repeat (16) idle();
    chk("tmo_not_yet", frame_err, 0);
    chk("tmo_busy_before", busy, 1);
    idle();
    chk("tmo_err", frame_err, 1);
    chk("tmo_busy_after", busy, 0);
    idle();
    chk("tmo_err_one_cycle", frame_err, 0);
    put(8'hA5); put(8'h02); put(8'h11);
`else
    repeat (20) idle();
    chk("stall_busy", busy, 1);
    chk("stall_no_err", frame_err, 0);
`endif

    // Reset mid-frame
    take = 1'b0;
    res  = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_len", frame_len, 0);
    chk("midrst_rd", rd_data, 0);
    chk("midrst_valid", frame_valid, 0);
    chk("midrst_err", frame_err, 0);
    res = 1'b0;
    idle();
    chk("midrst_no_pulse", frame_err, 0);
    put(8'hA5); put(8'h02); put(8'h11); put(8'h22); put(8'h31);
    chk("postrst_valid", frame_valid, 1);
    chk("postrst_len", frame_len, 2);
    rd(4'd1, 8'h22, "postrst_rd1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
